// File: rtl/dma_arbiter.sv
// Round-robin arbiter sharing one write-only DMA engine between NUM_REQ requesters.
// Latches the winner's address/data, sequences the engine busy handshake, returns ack/err.
module dma_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [7*NUM_REQ-1:0]    req_addr,
  input  logic [18*NUM_REQ-1:0]   req_dat,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    err,
  output logic                    dma_we,
  output logic [6:0]              dma_dat_addr,
  output logic [17:0]             dma_dat_w,
  input  logic                    dma_busy,
  output logic                    grant_valid,
  output logic [2:0]              grant_id
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 18;
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_ACK
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [2:0]           last, last_nxt;
  logic [NUM_REQ-1:0]   ack_nxt;
  logic                 err_nxt, we_nxt, gv_nxt;
  logic [AW-1:0]        addr_nxt, sel_addr;
  logic [DW-1:0]        dat_nxt, sel_dat;
  logic [2:0]           gid_nxt, pick_id, id_hi, id_lo;
  logic                 pick_found, found_hi, found_lo;

  // Round-robin pick: first request above last, otherwise lowest request overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    id_hi    = '0;
    id_lo    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && !found_lo) begin
        found_lo = 1'b1;
        id_lo    = 3'(j);
      end
      if (req[j] && !found_hi && (3'(j) > last)) begin
        found_hi = 1'b1;
        id_hi    = 3'(j);
      end
    end
    pick_found = found_lo;
    pick_id    = found_hi ? id_hi : id_lo;
  end

  // Payload mux for the winning requester.
  always_comb begin
    sel_addr = '0;
    sel_dat  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (3'(j) == pick_id) begin
        sel_addr = req_addr[j*AW +: AW];
        sel_dat  = req_dat[j*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    ack_nxt   = '0;
    err_nxt   = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = dma_dat_addr;
    dat_nxt   = dma_dat_w;
    gv_nxt    = grant_valid;
    gid_nxt   = grant_id;
    case (state)
      S_IDLE: begin
        if (!dma_busy && pick_found) begin
          addr_nxt  = sel_addr;
          dat_nxt   = sel_dat;
          gid_nxt   = pick_id;
          gv_nxt    = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (dma_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // Engine never started: complete with error so the requester is not stuck.
          ack_nxt   = NUM_REQ'(1) << grant_id;
          err_nxt   = 1'b1;
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!dma_busy) begin
          ack_nxt   = NUM_REQ'(1) << grant_id;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        last_nxt  = grant_id;
        gv_nxt    = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last         <= 3'(NUM_REQ - 1);
      ack          <= '0;
      err          <= 1'b0;
      dma_we       <= 1'b0;
      dma_dat_addr <= '0;
      dma_dat_w    <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      last         <= last_nxt;
      ack          <= ack_nxt;
      err          <= err_nxt;
      dma_we       <= we_nxt;
      dma_dat_addr <= addr_nxt;
      dma_dat_w    <= dat_nxt;
      grant_valid  <= gv_nxt;
      grant_id     <= gid_nxt;
    end
  end

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter: engine model, transaction-level reference, directed and random traffic.
module tb_dma_arbiter;

  localparam int NR = 2;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NR-1:0]     req;
  logic [7*NR-1:0]   req_addr;
  logic [18*NR-1:0]  req_dat;
  logic [NR-1:0]     ack;
  logic              err;
  logic              dma_we;
  logic [6:0]        dma_dat_addr;
  logic [17:0]       dma_dat_w;
  logic              dma_busy;
  logic              grant_valid;
  logic [2:0]        grant_id;

  logic force_busy;
  logic eng_busy;
  logic eng_en;
  int   eng_len;
  int   eng_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int we_cnt   = 0;
  int we_cyc   = 0;

  assign dma_busy = force_busy | eng_busy;

  dma_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_addr(req_addr), .req_dat(req_dat),
    .ack(ack), .err(err), .dma_we(dma_we), .dma_dat_addr(dma_dat_addr),
    .dma_dat_w(dma_dat_w), .dma_busy(dma_busy), .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine: after seeing a write strobe it stays busy for eng_len cycles (0 = never starts).
  always @(posedge clk) begin
    #2;
    if (!resetn) eng_cnt = 0;
    else if (eng_cnt > 0) eng_cnt = eng_cnt - 1;
    else if (dma_we && eng_en) eng_cnt = eng_len;
    eng_busy = (eng_cnt > 0);
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (dma_we) begin
      we_cnt++;
      we_cyc = cyc;
    end
  end

  // Reference: a grant is a transaction with an age; outputs follow from its age and busy history.
  logic          m_active, m_saw, m_ackhi;
  int            m_age, m_last, e_gid, idx;
  logic [NR-1:0] e_ack;
  logic          e_err, e_we, e_gv, found;
  logic [6:0]    e_addr;
  logic [17:0]   e_dat;

  always @(posedge clk) begin
    if (!resetn) begin
      m_active = 0; m_saw = 0; m_ackhi = 0; m_age = 0; m_last = NR - 1;
      e_ack = '0; e_err = 0; e_we = 0; e_gv = 0; e_gid = 0; e_addr = '0; e_dat = '0;
    end else if (m_ackhi) begin
      m_ackhi = 0; m_active = 0; m_last = e_gid;
      e_ack = '0; e_err = 0; e_gv = 0;
    end else if (!m_active) begin
      if (!dma_busy && req != '0) begin
        found = 0;
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (!found && req[idx]) begin
            found = 1;
            e_gid = idx;
          end
        end
        e_addr = req_addr[e_gid*7 +: 7];
        e_dat  = req_dat[e_gid*18 +: 18];
        e_we = 1; e_gv = 1; m_active = 1; m_age = 0; m_saw = 0;
      end
    end else begin
      m_age++;
      e_we = 0;
      if (m_age >= 2) begin
        if (!m_saw) begin
          if (dma_busy) m_saw = 1;
          else if (m_age - 1 >= TO) begin
            m_ackhi = 1; e_ack = NR'(1) << e_gid; e_err = 1;
          end
        end else if (!dma_busy) begin
          m_ackhi = 1; e_ack = NR'(1) << e_gid;
        end
      end
    end
    #1;
    check("ack", 32'(ack), 32'(e_ack));
    check("err", 32'(err), 32'(e_err));
    check("dma_we", 32'(dma_we), 32'(e_we));
    check("dma_dat_addr", 32'(dma_dat_addr), 32'(e_addr));
    check("dma_dat_w", 32'(dma_dat_w), 32'(e_dat));
    check("grant_valid", 32'(grant_valid), 32'(e_gv));
    check("grant_id", 32'(grant_id), 32'(e_gid));
  end

  task automatic wait_ack(input int budget, output logic [NR-1:0] a, output logic e,
                          output int gid, output int acyc);
    a = '0; e = 0; gid = -1; acyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack != '0) begin
        a = ack; e = err; gid = int'(grant_id); acyc = cyc;
        return;
      end
    end
    check("ack_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0; req = '0; force_busy = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  logic [NR-1:0] a;
  logic          e;
  int            gid, acyc;

  initial begin
    resetn = 0; req = '0; req_addr = '0; req_dat = '0;
    force_busy = 0; eng_busy = 0; eng_en = 1; eng_len = 20; eng_cnt = 0;
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    check("reset_ack", 32'(ack), 32'(0));
    check("reset_gv_we_err", 32'({grant_valid, dma_we, err}), 32'(0));
    check("reset_addr_dat", 32'({dma_dat_addr, dma_dat_w}), 32'(0));

    // Single request with a 20-cycle engine.
    we_cnt = 0;
    req_addr[6:0] = 7'h15; req_dat[17:0] = 18'h3C000; req = 2'b01;
    wait_ack(100, a, e, gid, acyc);
    check("single_ack", 32'(a), 32'h1);
    check("single_err", 32'(e), 32'h0);
    check("single_addr", 32'(dma_dat_addr), 32'h15);
    check("single_dat", 32'(dma_dat_w), 32'h3C000);
    check("single_latency", 32'(acyc - we_cyc), 32'd21);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("single_we_pulses", 32'(we_cnt), 32'd1);

    // Simultaneous requests right after reset.
    do_reset();
    eng_len = 3; we_cnt = 0;
    req_addr = {7'h2A, 7'h11}; req_dat = {18'h12345, 18'h0ABCD}; req = 2'b11;
    wait_ack(100, a, e, gid, acyc);
    check("simul_first", 32'(a), 32'h1);
    req[0] = 0;
    wait_ack(100, a, e, gid, acyc);
    check("simul_second", 32'(a), 32'h2);
    check("simul_second_dat", 32'(dma_dat_w), 32'h12345);
    req[1] = 0;
    repeat (3) @(negedge clk);
    check("simul_we_pulses", 32'(we_cnt), 32'd2);

    // Rotation with both requests held.
    req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      wait_ack(100, a, e, gid, acyc);
      check("rotation_gid", 32'(gid), 32'(t % 2));
    end
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Engine never starts.
    eng_en = 0;
    req = 2'b01;
    wait_ack(100, a, e, gid, acyc);
    check("timeout_ack", 32'(a), 32'h1);
    check("timeout_err", 32'(e), 32'h1);
    check("timeout_latency", 32'(acyc - we_cyc), 32'd9);
    req = 2'b00;
    eng_en = 1;
    @(negedge clk);
    req = 2'b10;
    wait_ack(100, a, e, gid, acyc);
    check("after_timeout_ack", 32'(a), 32'h2);
    check("after_timeout_err", 32'(e), 32'h0);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Busy engine at idle blocks grants.
    force_busy = 1; we_cnt = 0; req = 2'b10;
    repeat (12) @(negedge clk);
    check("busy_idle_no_we", 32'(we_cnt), 32'd0);
    check("busy_idle_no_gv", 32'(grant_valid), 32'd0);
    force_busy = 0;
    @(posedge clk); #1;
    check("busy_release_we", 32'(dma_we), 32'h1);
    check("busy_release_gid", 32'(grant_id), 32'h1);
    wait_ack(100, a, e, gid, acyc);
    check("busy_release_ack", 32'(a), 32'h2);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Reset in the middle of a transfer.
    eng_len = 20; req = 2'b01;
    repeat (6) @(negedge clk);
    check("midreset_pre_gv", 32'(grant_valid), 32'h1);
    resetn = 0; req = 2'b00;
    #1;
    check("midreset_ack", 32'(ack), 32'h0);
    check("midreset_ctrl", 32'({grant_valid, dma_we, err, grant_id}), 32'h0);
    check("midreset_addr_dat", 32'({dma_dat_addr, dma_dat_w}), 32'h0);
    repeat (3) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    eng_len = 4; req = 2'b01;
    wait_ack(100, a, e, gid, acyc);
    check("postreset_ack", 32'(a), 32'h1);
    check("postreset_gid", 32'(gid), 32'h0);
    req = 2'b00;
    repeat (3) @(negedge clk);

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack[i]) req[i] = 0;
        else if (!req[i] && $urandom_range(3) == 0) begin
          req_addr[i*7 +: 7]  = 7'($urandom);
          req_dat[i*18 +: 18] = 18'($urandom);
          req[i] = 1;
        end
      end
      eng_len    = $urandom_range(6);
      eng_en     = ($urandom_range(9) != 0);
      force_busy = ($urandom_range(15) == 0);
    end
    req = '0; force_busy = 0; eng_en = 1;
    for (int i = 0; i < 100 && grant_valid; i++) @(negedge clk);
    check("final_idle", 32'(grant_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
